// File: rtl/tristate_bus_responder.sv
// Tri-state bus target: writes captured to a register file; reads driven after TURN_CYC idle cycles.
// Latency: write ack one cycle after request, read data TURN_CYC cycles after; initiator holds cs until ack.
module tristate_bus_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] bus,
  output logic              ack,
  output logic              oe
);

  localparam int          NREG    = 2 ** ADDR_W;
  localparam logic [3:0]  TURN_M1 = 4'(TURN_CYC - 1);

  if (TURN_CYC > 15) begin : g_turn_chk
    $error("tristate_bus_responder: TURN_CYC must be 0..15");
  end

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_DRIVE, S_WACK, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nx;
  logic                w_load_rd;
  logic                w_wr_en;
  logic                w_rd_req;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]   r_rd_q;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic                r_ack;
  logic                r_oe;

  // With no turnaround the read address comes straight off the port on the request edge.
  assign w_rd_addr = (r_state == S_IDLE) ? addr : r_addr_q;
  assign bus       = r_oe ? r_rd_q : {DATA_W{1'bz}};
  assign ack       = r_ack;
  assign oe        = r_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load_rd  = 1'b0;
    w_wr_en    = 1'b0;
    w_rd_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cs) begin
          if (we) begin
            w_wr_en    = 1'b1;
            w_state_nx = S_WACK;
          end else begin
            w_rd_req = 1'b1;
            if (TURN_CYC == 0) begin
              w_load_rd  = 1'b1;
              w_state_nx = S_DRIVE;
            end else begin
              w_cnt_nx   = TURN_M1;
              w_state_nx = S_TURN;
            end
          end
        end
      end
      S_TURN: begin
        if (!cs) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_load_rd  = 1'b1;
          w_state_nx = S_DRIVE;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      S_DRIVE: w_state_nx = S_WAIT;
      S_WACK:  w_state_nx = S_WAIT;
      S_WAIT: begin
        if (!cs) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so ack/oe are clean Moore outputs of the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_addr_q <= '0;
      r_rd_q   <= '0;
      r_ack    <= 1'b0;
      r_oe     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nx;
      r_ack <= (w_state_nx == S_DRIVE) || (w_state_nx == S_WACK);
      r_oe  <= (w_state_nx == S_DRIVE);
      if (w_rd_req) begin
        r_addr_q <= addr;
      end
      if (w_load_rd) begin
        r_rd_q <= r_regs[w_rd_addr];
      end
      if (w_wr_en) begin
        r_regs[addr] <= bus;
      end
    end
  end

endmodule

// File: tb/tb_tristate_bus_responder.sv
// Directed bench: three responders built with turnaround 0, 1 and 3, each on its own bus.
module tb_tristate_bus_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cs_v = 3'b000;
  logic [2:0] we_v = 3'b000;
  logic [1:0] addr_a [3];
  logic       drv_en [3];
  logic [7:0] drv_dat [3];
  wire  [2:0] ack_v;
  wire  [2:0] oe_v;
  wire  [7:0] bus_0;
  wire  [7:0] bus_1;
  wire  [7:0] bus_2;
  logic [7:0] busv [3];

  int checks = 0;
  int errors = 0;
  int contention = 0;
  int turn_of [3] = '{0, 1, 3};
  logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  assign bus_0 = drv_en[0] ? drv_dat[0] : 8'bz;
  assign bus_1 = drv_en[1] ? drv_dat[1] : 8'bz;
  assign bus_2 = drv_en[2] ? drv_dat[2] : 8'bz;

  always_comb begin
    busv[0] = bus_0;
    busv[1] = bus_1;
    busv[2] = bus_2;
  end

  tristate_bus_responder #(.DATA_W(8), .ADDR_W(2), .TURN_CYC(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .we(we_v[0]), .addr(addr_a[0]),
    .bus(bus_0), .ack(ack_v[0]), .oe(oe_v[0]));
  tristate_bus_responder #(.DATA_W(8), .ADDR_W(2), .TURN_CYC(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .we(we_v[1]), .addr(addr_a[1]),
    .bus(bus_1), .ack(ack_v[1]), .oe(oe_v[1]));
  tristate_bus_responder #(.DATA_W(8), .ADDR_W(2), .TURN_CYC(3)) u_t3 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[2]), .we(we_v[2]), .addr(addr_a[2]),
    .bus(bus_2), .ack(ack_v[2]), .oe(oe_v[2]));

  // Both ends enabled on the same bus at once is contention.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (drv_en[k] && oe_v[k]) contention++;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int k, input logic [1:0] a, input logic [7:0] d);
    drv_en[k]  = 1'b1;
    drv_dat[k] = d;
    cs_v[k]    = 1'b1;
    we_v[k]    = 1'b1;
    addr_a[k]  = a;
    chk1("wr_idle_oe", oe_v[k], 1'b0);
    tick();
    chk1("wr_ack", ack_v[k], 1'b1);
    chk1("wr_oe", oe_v[k], 1'b0);
    chk8("wr_bus", busv[k], d);
    drv_en[k] = 1'b0;
    cs_v[k]   = 1'b0;
    we_v[k]   = 1'b0;
    tick();
    chk1("wr_ack_fall", ack_v[k], 1'b0);
    tick();
  endtask

  task automatic rd(input int k, input logic [1:0] a, input logic [7:0] exp);
    drv_en[k] = 1'b0;
    cs_v[k]   = 1'b1;
    we_v[k]   = 1'b0;
    addr_a[k] = a;
    tick();
    for (int i = 0; i < turn_of[k]; i++) begin
      chk1("rd_turn_ack", ack_v[k], 1'b0);
      chk1("rd_turn_oe", oe_v[k], 1'b0);
      addr_a[k] = ~a;
      we_v[k]   = 1'b1;
      tick();
    end
    chk1("rd_ack", ack_v[k], 1'b1);
    chk1("rd_oe", oe_v[k], 1'b1);
    chk8("rd_data", busv[k], exp);
    cs_v[k] = 1'b0;
    we_v[k] = 1'b0;
    tick();
    chk1("rd_ack_fall", ack_v[k], 1'b0);
    chk1("rd_oe_fall", oe_v[k], 1'b0);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr_a[k]  = 2'd0;
      drv_en[k]  = 1'b0;
      drv_dat[k] = 8'h00;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk1("rst_ack", ack_v[k], 1'b0);
      chk1("rst_oe", oe_v[k], 1'b0);
    end
    rst_n = 1'b1;

    // Idle: the responder must leave the bus to whoever drives it.
    drv_en[1]  = 1'b1;
    drv_dat[1] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("idle_ack", ack_v[1], 1'b0);
      chk1("idle_oe", oe_v[1], 1'b0);
      chk8("idle_bus", busv[1], 8'h3C);
    end
    drv_en[1] = 1'b0;
    tick();

    wr(1, 2'd2, 8'hA5);
    rd(1, 2'd2, 8'hA5);

    for (int k = 0; k < 3; k += 2) begin
      for (int i = 0; i < 4; i++) wr(k, 2'(i), pat[i]);
      for (int i = 3; i >= 0; i--) rd(k, 2'(i), pat[i]);
    end

    // Read aborted mid-turnaround on the 3-cycle build.
    cs_v[2]   = 1'b1;
    we_v[2]   = 1'b0;
    addr_a[2] = 2'd0;
    tick();
    chk1("abort_oe0", oe_v[2], 1'b0);
    cs_v[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("abort_ack", ack_v[2], 1'b0);
      chk1("abort_oe", oe_v[2], 1'b0);
    end
    wr(2, 2'd1, 8'h5A);
    rd(2, 2'd1, 8'h5A);

    // cs held after ack: exactly one transfer until cs drops.
    drv_en[1]  = 1'b1;
    drv_dat[1] = 8'h77;
    cs_v[1]    = 1'b1;
    we_v[1]    = 1'b1;
    addr_a[1]  = 2'd3;
    tick();
    chk1("hold_ack", ack_v[1], 1'b1);
    drv_en[1]  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("hold_no_ack", ack_v[1], 1'b0);
      chk1("hold_no_oe", oe_v[1], 1'b0);
    end
    cs_v[1] = 1'b0;
    we_v[1] = 1'b0;
    tick();
    rd(1, 2'd3, 8'h77);

    // Reset asserted while driving: bus must be released without a clock edge.
    cs_v[1]   = 1'b1;
    addr_a[1] = 2'd2;
    tick();
    tick();
    chk1("pre_rst_oe", oe_v[1], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_async_oe", oe_v[1], 1'b0);
    chk1("rst_async_ack", ack_v[1], 1'b0);
    cs_v[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd(1, 2'd2, 8'h00);

    checks++;
    assert (contention == 0) else begin
      errors++;
      $error("FAIL contention observed=%0d expected=0", contention);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
